// File: rtl/bsg_tag_trace_sequencer.sv
// Trace sequencer: replays a boot-ROM program that bit-serialises bsg_tag frames onto
// masked tag lines, with timed/event waits and a single-level repeat loop.
module bsg_tag_trace_sequencer #(
  parameter int num_masters_p       = 2,
  parameter int num_clients_p       = 32,
  parameter int max_payload_width_p = 10,
  parameter int num_events_p        = 4,
  parameter int rom_addr_width_p    = 8,
  localparam int client_width_lp    = (num_clients_p > 1) ? $clog2(num_clients_p) : 1,
  localparam int len_width_lp       = (max_payload_width_p + 1 > 1) ? $clog2(max_payload_width_p + 1) : 1,
  localparam int event_width_lp     = (num_events_p > 1) ? $clog2(num_events_p) : 1,
  localparam int rom_data_width_lp  = 4 + num_masters_p + client_width_lp + 1 + len_width_lp + max_payload_width_p
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         en_i,
  output logic [rom_addr_width_p-1:0]  rom_addr_o,
  input  logic [rom_data_width_lp-1:0] rom_data_i,
  input  logic [num_events_p-1:0]      events_i,
  output logic [num_masters_p-1:0]     tag_data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         error_o
);

  localparam int frame_width_lp   = 2 + client_width_lp + len_width_lp + max_payload_width_p;
  localparam int bit_cnt_width_lp = $clog2(frame_width_lp);

  localparam logic [3:0] op_nop        = 4'd0;
  localparam logic [3:0] op_send       = 4'd1;
  localparam logic [3:0] op_wait_cyc   = 4'd2;
  localparam logic [3:0] op_wait_evt   = 4'd3;
  localparam logic [3:0] op_loop_start = 4'd4;
  localparam logic [3:0] op_loop_end   = 4'd5;
  localparam logic [3:0] op_finish     = 4'd6;

  typedef enum logic [2:0] {
    s_fetch, s_shift, s_wait_cyc, s_wait_evt, s_done, s_error
  } state_e;

  logic [3:0]                     op_f;
  logic [num_masters_p-1:0]       mask_f;
  logic [client_width_lp-1:0]     client_f;
  logic                           dnr_f;
  logic [len_width_lp-1:0]        len_f;
  logic [max_payload_width_p-1:0] payload_f;

  assign op_f      = rom_data_i[rom_data_width_lp-1 -: 4];
  assign mask_f    = rom_data_i[rom_data_width_lp-5 -: num_masters_p];
  assign client_f  = rom_data_i[max_payload_width_p+len_width_lp+1 +: client_width_lp];
  assign dnr_f     = rom_data_i[max_payload_width_p+len_width_lp];
  assign len_f     = rom_data_i[max_payload_width_p +: len_width_lp];
  assign payload_f = rom_data_i[0 +: max_payload_width_p];

  // Frame laid out in transmit order, bit 0 first on the wire.
  logic [frame_width_lp-1:0] frame_bits;
  assign frame_bits[0] = 1'b1;
  assign frame_bits[client_width_lp+1] = dnr_f;

  genvar gi;
  generate
    for (gi = 0; gi < client_width_lp; gi++) begin : g_client
      assign frame_bits[1+gi] = client_f[client_width_lp-1-gi];
    end
    for (gi = 0; gi < len_width_lp; gi++) begin : g_len
      assign frame_bits[client_width_lp+2+gi] = len_f[len_width_lp-1-gi];
    end
    for (gi = 0; gi < max_payload_width_p; gi++) begin : g_payload
      assign frame_bits[client_width_lp+2+len_width_lp+gi] = payload_f[gi];
    end
  endgenerate

  state_e                         state_reg;
  logic [rom_addr_width_p-1:0]    pc_reg;
  logic [num_masters_p-1:0]       mask_reg;
  logic [frame_width_lp-1:0]      frame_reg;
  logic [bit_cnt_width_lp-1:0]    bits_left_reg;
  logic [max_payload_width_p-1:0] cnt_reg;
  logic [event_width_lp-1:0]      evt_idx_reg;
  logic [max_payload_width_p-1:0] loop_cnt_reg;
  logic [rom_addr_width_p-1:0]    loop_addr_reg;
  logic                           loop_active_reg;
  logic                           pc_last;

  assign rom_addr_o = pc_reg;
  assign pc_last    = &pc_reg;

  task automatic go_error();
    state_reg <= s_error;
    error_o   <= 1'b1;
    busy_o    <= 1'b0;
  endtask

  // The pc never wraps; stepping past the last address is fatal.
  task automatic advance_pc();
    if (pc_last) go_error();
    else pc_reg <= pc_reg + rom_addr_width_p'(1);
  endtask

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg       <= s_fetch;
      pc_reg          <= '0;
      tag_data_o      <= '0;
      busy_o          <= 1'b1;
      done_o          <= 1'b0;
      error_o         <= 1'b0;
      mask_reg        <= '0;
      frame_reg       <= '0;
      bits_left_reg   <= '0;
      cnt_reg         <= '0;
      evt_idx_reg     <= '0;
      loop_cnt_reg    <= '0;
      loop_addr_reg   <= '0;
      loop_active_reg <= 1'b0;
    end else begin
      tag_data_o <= '0;
      case (state_reg)
        s_fetch: if (en_i) begin
          case (op_f)
            op_nop: advance_pc();
            op_send: begin
              if (int'(len_f) > max_payload_width_p) go_error();
              else begin
                mask_reg      <= mask_f;
                frame_reg     <= frame_bits >> 1;
                tag_data_o    <= mask_f & {num_masters_p{frame_bits[0]}};
                bits_left_reg <= bit_cnt_width_lp'(1 + client_width_lp + len_width_lp)
                               + bit_cnt_width_lp'(len_f);
                state_reg     <= s_shift;
              end
            end
            op_wait_cyc: begin
              if (payload_f == '0) advance_pc();
              else begin
                cnt_reg   <= payload_f;
                state_reg <= s_wait_cyc;
              end
            end
            op_wait_evt: begin
              if (int'(payload_f) >= num_events_p) go_error();
              else begin
                evt_idx_reg <= payload_f[event_width_lp-1:0];
                state_reg   <= s_wait_evt;
              end
            end
            op_loop_start: begin
              if (loop_active_reg || pc_last) go_error();
              else begin
                loop_cnt_reg    <= payload_f;
                loop_addr_reg   <= pc_reg + rom_addr_width_p'(1);
                loop_active_reg <= 1'b1;
                pc_reg          <= pc_reg + rom_addr_width_p'(1);
              end
            end
            op_loop_end: begin
              if (!loop_active_reg) go_error();
              else if (loop_cnt_reg > max_payload_width_p'(1)) begin
                loop_cnt_reg <= loop_cnt_reg - max_payload_width_p'(1);
                pc_reg       <= loop_addr_reg;
              end else begin
                loop_active_reg <= 1'b0;
                advance_pc();
              end
            end
            op_finish: begin
              state_reg <= s_done;
              done_o    <= 1'b1;
              busy_o    <= 1'b0;
            end
            default: go_error();
          endcase
        end
        s_shift: begin
          if (bits_left_reg == '0) begin
            state_reg <= s_fetch;
            advance_pc();
          end else begin
            tag_data_o    <= mask_reg & {num_masters_p{frame_reg[0]}};
            frame_reg     <= frame_reg >> 1;
            bits_left_reg <= bits_left_reg - bit_cnt_width_lp'(1);
          end
        end
        s_wait_cyc: begin
          if (cnt_reg == max_payload_width_p'(1)) begin
            state_reg <= s_fetch;
            advance_pc();
          end else begin
            cnt_reg <= cnt_reg - max_payload_width_p'(1);
          end
        end
        s_wait_evt: begin
          if (events_i[evt_idx_reg]) begin
            state_reg <= s_fetch;
            advance_pc();
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_tag_trace_sequencer.sv
// Directed bench for bsg_tag_trace_sequencer at default parameters, driven from a behavioural ROM.
module tb_bsg_tag_trace_sequencer;

  localparam int W = 26;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic [7:0]    rom_addr;
  logic [W-1:0]  rom_data;
  logic [3:0]    events;
  logic [1:0]    tag;
  logic          busy, done, error;
  logic [W-1:0]  rom [256];

  int n_vec  = 0;
  int n_miss = 0;

  assign rom_data = rom[rom_addr];
  always #5 clk = ~clk;

  bsg_tag_trace_sequencer dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .en_i       (en),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .events_i   (events),
    .tag_data_o (tag),
    .busy_o     (busy),
    .done_o     (done),
    .error_o    (error)
  );

  task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ins(input int op, input int mask, input int client,
                                       input int dnr, input int len, input int payload);
    return {op[3:0], mask[1:0], client[4:0], dnr[0], len[3:0], payload[9:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = '0;
  endtask

  // Holds reset for a cycle, checks reset values, releases on a falling edge.
  task automatic reset_dut(input logic en_val);
    reset_n = 1'b0;
    events  = '0;
    @(posedge clk);
    #1;
    expect_eq("rst_busy", busy, 1);
    expect_eq("rst_done", done, 0);
    expect_eq("rst_error", error, 0);
    expect_eq("rst_tag", tag, 0);
    expect_eq("rst_pc", rom_addr, 0);
    @(negedge clk);
    en      = en_val;
    reset_n = 1'b1;
  endtask

  logic [14:0] seq;
  logic [W-1:0] bad [3];
  int both, odd, done_cyc;

  initial begin
    reset_n = 1'b0;
    en      = 1'b1;
    events  = '0;
    seq     = 15'b100011101000101;

    // SEND client=3 dnr=1 len=4 payload=0xA on line 0
    $display("test send_frame");
    clear_rom();
    rom[0] = ins(1, 1, 3, 1, 4, 10);
    rom[1] = ins(6, 0, 0, 0, 0, 0);
    reset_dut(1'b1);
    for (int i = 0; i < 15; i++) begin
      tick();
      expect_eq("send_bit", tag, {30'd0, 1'b0, seq[14-i]});
    end
    tick();
    expect_eq("send_gap_tag", tag, 0);
    expect_eq("send_gap_done", done, 0);
    tick();
    expect_eq("send_done", done, 1);
    expect_eq("send_busy", busy, 0);
    expect_eq("send_pc", rom_addr, 1);

    $display("test wait_cyc_5");
    clear_rom();
    rom[0] = ins(2, 0, 0, 0, 0, 5);
    rom[1] = ins(6, 0, 0, 0, 0, 0);
    reset_dut(1'b1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      expect_eq("wcyc_busy", busy, 1);
    end
    expect_eq("wcyc_done_early", done, 0);
    tick();
    expect_eq("wcyc_done", done, 1);
    expect_eq("wcyc_busy_end", busy, 0);

    $display("test wait_cyc_0");
    rom[0] = ins(2, 0, 0, 0, 0, 0);
    reset_dut(1'b1);
    tick();
    expect_eq("wcyc0_pc", rom_addr, 1);
    expect_eq("wcyc0_done_early", done, 0);
    tick();
    expect_eq("wcyc0_done", done, 1);

    $display("test wait_evt_2");
    clear_rom();
    rom[0] = ins(3, 0, 0, 0, 0, 2);
    rom[1] = ins(6, 0, 0, 0, 0, 0);
    reset_dut(1'b1);
    for (int i = 1; i <= 20; i++) begin
      events = 4'(i & 3);
      tick();
      expect_eq("wevt_hold_pc", rom_addr, 0);
    end
    events = 4'b0100;
    tick();
    expect_eq("wevt_pc", rom_addr, 1);
    expect_eq("wevt_done_early", done, 0);
    tick();
    expect_eq("wevt_done", done, 1);

    $display("test loop_3");
    clear_rom();
    rom[0] = ins(4, 0, 0, 0, 0, 3);
    rom[1] = ins(1, 3, 1, 0, 0, 0);
    rom[2] = ins(5, 0, 0, 0, 0, 0);
    rom[3] = ins(6, 0, 0, 0, 0, 0);
    reset_dut(1'b1);
    both = 0; odd = 0; done_cyc = 0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (tag == 2'b11) both++;
      if (tag == 2'b01 || tag == 2'b10) odd++;
      if (done && done_cyc == 0) done_cyc = c;
    end
    expect_eq("loop_ones", both, 6);
    expect_eq("loop_split", odd, 0);
    expect_eq("loop_done_cyc", done_cyc, 41);
    expect_eq("loop_error", error, 0);

    $display("test loop_nested");
    clear_rom();
    rom[0] = ins(4, 0, 0, 0, 0, 2);
    rom[1] = ins(4, 0, 0, 0, 0, 2);
    reset_dut(1'b1);
    tick();
    tick();
    expect_eq("nest_error", error, 1);
    expect_eq("nest_busy", busy, 0);
    expect_eq("nest_done", done, 0);
    expect_eq("nest_pc", rom_addr, 1);

    $display("test loop_end_orphan");
    clear_rom();
    rom[0] = ins(5, 0, 0, 0, 0, 0);
    reset_dut(1'b1);
    tick();
    expect_eq("orphan_error", error, 1);
    expect_eq("orphan_pc", rom_addr, 0);

    bad[0] = ins(9, 3, 0, 0, 0, 0);
    bad[1] = ins(1, 3, 5, 1, 11, 1023);
    bad[2] = ins(3, 0, 0, 0, 0, 4);
    for (int k = 0; k < 3; k++) begin
      $display("test illegal_%0d", k);
      clear_rom();
      rom[0] = bad[k];
      reset_dut(1'b1);
      tick();
      expect_eq("ill_error", error, 1);
      expect_eq("ill_busy", busy, 0);
      expect_eq("ill_tag", tag, 0);
      repeat (3) tick();
      expect_eq("ill_pc", rom_addr, 0);
      expect_eq("ill_tag_late", tag, 0);
      expect_eq("ill_done", done, 0);
    end

    $display("test pc_overflow");
    clear_rom();
    reset_dut(1'b1);
    repeat (255) tick();
    expect_eq("ovf_pc_top", rom_addr, 255);
    expect_eq("ovf_no_error", error, 0);
    tick();
    expect_eq("ovf_error", error, 1);
    expect_eq("ovf_pc", rom_addr, 255);

    $display("test enable_gating");
    clear_rom();
    rom[0] = ins(1, 1, 3, 1, 4, 10);
    rom[1] = ins(6, 0, 0, 0, 0, 0);
    reset_dut(1'b0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      expect_eq("en_hold_pc", rom_addr, 0);
    end
    expect_eq("en_hold_tag", tag, 0);
    expect_eq("en_hold_busy", busy, 1);
    en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 2) en = 1'b0;
      expect_eq("en_send_bit", tag, {30'd0, 1'b0, seq[14-i]});
    end
    tick();
    expect_eq("en_after_tag", tag, 0);
    expect_eq("en_after_pc", rom_addr, 1);
    tick();
    tick();
    expect_eq("en_stall_done", done, 0);
    en = 1'b1;
    tick();
    expect_eq("en_done", done, 1);

    $display("test reset_mid_frame");
    reset_dut(1'b1);
    repeat (5) tick();
    expect_eq("mid_tag", tag, 1);
    #2;
    reset_n = 1'b0;
    #1;
    expect_eq("mid_rst_tag", tag, 0);
    expect_eq("mid_rst_pc", rom_addr, 0);
    expect_eq("mid_rst_busy", busy, 1);
    expect_eq("mid_rst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    expect_eq("mid_restart_tag", tag, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
